// File: rtl/fifo_dma_req_ctrl.sv
// fifo_dma_req_ctrl
//   Generates the HPS DMA peripheral-request handshake (req/single/ack) for
//   one TX FIFO (memory->FIFO) and one RX FIFO (FIFO->memory). It requests a
//   burst when a full burst fits and a single transfer for any remainder. It
//   also counts completed handshakes and flags an ack that arrives when no
//   request is outstanding.
//
// Ports
//   clk_i                  sole clock
//   reset_n_i              asynchronous reset, active low
//   tx_en_i / rx_en_i      enable request generation per direction
//   tx_fill_i / rx_fill_i  FIFO fill levels (words)
//   *_dma_req_o            burst request
//   *_dma_single_o         single request
//   *_dma_ack_i            acknowledge from the HPS DMAC
//   *_hs_count_o           completed handshakes (wrapping)
//   ack_err_o              sticky {rx,tx} flags: ack seen while idle/holding off

// Per-direction request FSM.
//   state   | meaning
//   S_IDLE  | sampling en/avail, no request outstanding
//   S_REQ   | request (burst or single) held until ack
//   S_ACKLO | request dropped, waiting for ack to fall
//   S_HOLD  | holdoff down-count before the next evaluation
module fifo_dma_req_chan #(
  parameter int FILL_W    = 9,
  parameter int BURST_LEN = 8,
  parameter int HOLDOFF   = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              en_i,
  input  logic [FILL_W:0]   avail_i,
  input  logic              ack_i,
  output logic              req_o,
  output logic              single_o,
  output logic [CNT_W-1:0]  hs_count_o,
  output logic              ack_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACKLO, S_HOLD} state_e;

  localparam logic [FILL_W:0] BURST_TH  = (FILL_W+1)'(BURST_LEN);
  localparam logic [3:0]      HOLD_INIT = (HOLDOFF > 0) ? 4'(HOLDOFF - 1) : 4'd0;

  state_e           state_q, state_d;
  logic             burst_q, burst_d;
  logic [3:0]       hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             req_q, req_d;
  logic             single_q, single_d;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      burst_q  <= 1'b0;
      hold_q   <= 4'd0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      single_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      req_q    <= req_d;
      single_q <= single_d;
    end
  end

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (ack_i) err_d = 1'b1;
        if (en_i && (avail_i >= BURST_TH)) begin
          state_d = S_REQ;
          burst_d = 1'b1;
        end else if (en_i && (avail_i != '0)) begin
          state_d = S_REQ;
          burst_d = 1'b0;
        end
      end
      S_REQ: begin
        if (ack_i) state_d = S_ACKLO;
      end
      S_ACKLO: begin
        if (!ack_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (HOLDOFF == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
            hold_d  = HOLD_INIT;
          end
        end
      end
      S_HOLD: begin
        if (ack_i) err_d = 1'b1;
        if (hold_q == 4'd0) state_d = S_IDLE;
        else                hold_d  = hold_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so req/single are glitch-free
  // and drop on the same edge that sees ack.
  always_comb begin
    req_d    = (state_d == S_REQ) &&  burst_d;
    single_d = (state_d == S_REQ) && !burst_d;
  end

  assign req_o      = req_q;
  assign single_o   = single_q;
  assign hs_count_o = cnt_q;
  assign ack_err_o  = err_q;

endmodule

module fifo_dma_req_ctrl #(
  parameter int FIFO_DEPTH = 256,
  parameter int FILL_W     = 9,
  parameter int BURST_LEN  = 8,
  parameter int HOLDOFF    = 2,
  parameter int SYNC_ACK   = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              tx_en_i,
  input  logic              rx_en_i,
  input  logic [FILL_W-1:0] tx_fill_i,
  input  logic [FILL_W-1:0] rx_fill_i,
  output logic              tx_dma_req_o,
  output logic              tx_dma_single_o,
  input  logic              tx_dma_ack_i,
  output logic              rx_dma_req_o,
  output logic              rx_dma_single_o,
  input  logic              rx_dma_ack_i,
  output logic [CNT_W-1:0]  tx_hs_count_o,
  output logic [CNT_W-1:0]  rx_hs_count_o,
  output logic [1:0]        ack_err_o
);

  localparam logic [FILL_W:0] DEPTH_W = (FILL_W+1)'(FIFO_DEPTH);

  logic [FILL_W:0] tx_fill_w, tx_avail, rx_avail;
  logic            tx_ack, rx_ack;
  logic            tx_err, rx_err;

  // A fill level above the FIFO depth would underflow; treat it as no room.
  assign tx_fill_w = {1'b0, tx_fill_i};
  assign tx_avail  = (tx_fill_w > DEPTH_W) ? '0 : (DEPTH_W - tx_fill_w);
  assign rx_avail  = {1'b0, rx_fill_i};

  if (SYNC_ACK != 0) begin : g_sync
    logic [1:0] tx_sync_q, rx_sync_q;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        tx_sync_q <= 2'b00;
        rx_sync_q <= 2'b00;
      end else begin
        tx_sync_q <= {tx_sync_q[0], tx_dma_ack_i};
        rx_sync_q <= {rx_sync_q[0], rx_dma_ack_i};
      end
    end
    assign tx_ack = tx_sync_q[1];
    assign rx_ack = rx_sync_q[1];
  end else begin : g_nosync
    assign tx_ack = tx_dma_ack_i;
    assign rx_ack = rx_dma_ack_i;
  end

  fifo_dma_req_chan #(
    .FILL_W(FILL_W), .BURST_LEN(BURST_LEN), .HOLDOFF(HOLDOFF), .CNT_W(CNT_W)
  ) u_tx (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .en_i       (tx_en_i),
    .avail_i    (tx_avail),
    .ack_i      (tx_ack),
    .req_o      (tx_dma_req_o),
    .single_o   (tx_dma_single_o),
    .hs_count_o (tx_hs_count_o),
    .ack_err_o  (tx_err)
  );

  fifo_dma_req_chan #(
    .FILL_W(FILL_W), .BURST_LEN(BURST_LEN), .HOLDOFF(HOLDOFF), .CNT_W(CNT_W)
  ) u_rx (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .en_i       (rx_en_i),
    .avail_i    (rx_avail),
    .ack_i      (rx_ack),
    .req_o      (rx_dma_req_o),
    .single_o   (rx_dma_single_o),
    .hs_count_o (rx_hs_count_o),
    .ack_err_o  (rx_err)
  );

  assign ack_err_o = {rx_err, tx_err};

endmodule
